// File: rtl/vram_port_arbiter.sv
// Single-port vector RAM arbiter: CPU store-queue writes compete with vector-generator reads.
// Reads win unless a write has waited through MAX_VG_RUN consecutive read grants.
module vram_port_arbiter #(
    parameter int ADDR_W     = 13,
    parameter int MAX_VG_RUN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic              wr_gnt,
    input  logic              vg_req,
    input  logic [ADDR_W-1:0] vg_addr,
    output logic              vg_gnt,
    input  logic              vg_flush,
    output logic              vg_rvalid,
    output logic [7:0]        vg_rdata,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [7:0]        bram_din,
    output logic              bram_we,
    input  logic [7:0]        bram_dout,
    output logic [1:0]        state
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    localparam logic [3:0] RUN_MAX = 4'(MAX_VG_RUN);

    state_t              state_q, state_d;
    logic [3:0]          run_cnt_q, run_cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          din_q, din_d;
    logic                we_q, we_d;
    logic                rvalid_q, rvalid_d;
    logic                vg_gnt_c, wr_gnt_c;

    always_comb begin
        vg_gnt_c  = !rst && vg_req && !vg_flush && (!wr_req || (run_cnt_q < RUN_MAX));
        wr_gnt_c  = !rst && wr_req && !vg_gnt_c;
        state_d   = ST_IDLE;
        we_d      = 1'b0;
        addr_d    = addr_q;
        din_d     = din_q;
        run_cnt_d = wr_req ? run_cnt_q : 4'd0;
        // A flush drops whatever read result would have surfaced next cycle.
        rvalid_d  = (state_q == ST_READ) && !vg_flush;
        if (vg_gnt_c) begin
            addr_d  = vg_addr;
            state_d = ST_READ;
            if (wr_req && (run_cnt_q < RUN_MAX)) begin
                run_cnt_d = run_cnt_q + 4'd1;
            end
        end else if (wr_gnt_c) begin
            addr_d    = wr_addr;
            din_d     = wr_data;
            we_d      = 1'b1;
            state_d   = ST_WRITE;
            run_cnt_d = 4'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            run_cnt_q <= 4'd0;
            addr_q    <= '0;
            din_q     <= 8'd0;
            we_q      <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            we_q      <= we_d;
            rvalid_q  <= rvalid_d;
        end
    end

    assign vg_gnt    = vg_gnt_c;
    assign wr_gnt    = wr_gnt_c;
    assign vg_rvalid = rvalid_q;
    assign vg_rdata  = bram_dout;
    assign bram_addr = addr_q;
    assign bram_din  = din_q;
    assign bram_we   = we_q;
    assign state     = state_q;
endmodule
